axilite_csr_slave: RTL

AXI4-Lite responder exposing a bank of 32-bit control/status registers. It terminates the host-side AXI-Lite link driven by the host interface agent. It is the slave-side counterpart that the GPGPU top and its bench use for kernel-launch CSRs. Register contents are presented as a flat vector to downstream logic, along with per-register write strobes.

---
 rtl/axilite_csr_slave.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axilite_csr_slave.sv
// axilite_csr_slave: AXI4-Lite responder for a bank of 32-bit CSRs with flat register output and per-register write pulses.
module axilite_csr_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_axilite_awvalid_i,
  output logic                           s_axilite_awready_o,
  input  logic [ADDR_WIDTH-1:0]          s_axilite_awaddr_i,
  input  logic [2:0]                     s_axilite_awprot_i,
  input  logic                           s_axilite_wvalid_i,
  output logic                           s_axilite_wready_o,
  input  logic [DATA_WIDTH-1:0]          s_axilite_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        s_axilite_wstrb_i,
  output logic                           s_axilite_bvalid_o,
  input  logic                           s_axilite_bready_i,
  output logic [1:0]                     s_axilite_bresp_o,
  input  logic                           s_axilite_arvalid_i,
  output logic                           s_axilite_arready_o,
  input  logic [ADDR_WIDTH-1:0]          s_axilite_araddr_i,
  input  logic [2:0]                     s_axilite_arprot_i,
  output logic                           s_axilite_rvalid_o,
  input  logic                           s_axilite_rready_i,
  output logic [DATA_WIDTH-1:0]          s_axilite_rdata_o,
  output logic [1:0]                     s_axilite_rresp_o,
  output logic [DATA_WIDTH*NUM_REGS-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int unsigned IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam int unsigned SB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-3:0] NR = (ADDR_WIDTH-2)'(NUM_REGS);
  localparam logic [1:0] W_IDLE = 2'd0, W_HAVE_AW = 2'd1, W_HAVE_W = 2'd2, W_RESP = 2'd3;
  localparam logic R_IDLE = 1'b0, R_RESP = 1'b1;
  logic [1:0] w_state_q, w_state_d;
  logic r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SB-1:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH*NUM_REGS-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic aw_hs, w_hs, ar_hs, commit, aw_hit, ar_hit;
  logic [ADDR_WIDTH-1:0] aw_addr, aw_off, ar_off;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SB-1:0] w_strb;
  logic [IW-1:0] widx, ridx;
  logic unused;
  assign s_axilite_awready_o = w_state_q == W_IDLE || w_state_q == W_HAVE_W;
  assign s_axilite_wready_o  = w_state_q == W_IDLE || w_state_q == W_HAVE_AW;
  assign s_axilite_bvalid_o  = w_state_q == W_RESP;
  assign s_axilite_arready_o = r_state_q == R_IDLE;
  assign s_axilite_rvalid_o  = r_state_q == R_RESP;
  assign s_axilite_bresp_o   = bresp_q;
  assign s_axilite_rdata_o   = rdata_q;
  assign s_axilite_rresp_o   = rresp_q;
  assign regs_o              = regs_q;
  assign wr_pulse_o          = pulse_q;
  assign aw_hs   = s_axilite_awvalid_i && s_axilite_awready_o;
  assign w_hs    = s_axilite_wvalid_i && s_axilite_wready_o;
  assign ar_hs   = s_axilite_arvalid_i && s_axilite_arready_o;
  // The half arriving this cycle bypasses its latch so commit lands on the accepting edge.
  assign aw_addr = aw_hs ? s_axilite_awaddr_i : awaddr_q;
  assign w_data  = w_hs ? s_axilite_wdata_i : wdata_q;
  assign w_strb  = w_hs ? s_axilite_wstrb_i : wstrb_q;
  assign commit  = (aw_hs || w_state_q == W_HAVE_AW) && (w_hs || w_state_q == W_HAVE_W);
  assign aw_off  = aw_addr - BASE_ADDR;
  assign ar_off  = s_axilite_araddr_i - BASE_ADDR;
  assign aw_hit  = aw_addr >= BASE_ADDR && aw_off[ADDR_WIDTH-1:2] < NR;
  assign ar_hit  = s_axilite_araddr_i >= BASE_ADDR && ar_off[ADDR_WIDTH-1:2] < NR;
  assign widx    = aw_off[IW+1:2];
  assign ridx    = ar_off[IW+1:2];
  assign unused  = ^{s_axilite_awprot_i, s_axilite_arprot_i, aw_off[1:0], ar_off[1:0]};
  always_comb begin
    awaddr_d  = aw_hs ? s_axilite_awaddr_i : awaddr_q;
    wdata_d   = w_data;
    wstrb_d   = w_strb;
    w_state_d = commit ? W_RESP :
                w_state_q == W_RESP ? (s_axilite_bready_i ? W_IDLE : W_RESP) :
                aw_hs ? W_HAVE_AW : w_hs ? W_HAVE_W : w_state_q;
    bresp_d   = commit ? (aw_hit ? 2'b00 : 2'b10) : bresp_q;
    r_state_d = ar_hs ? R_RESP : (r_state_q == R_RESP && s_axilite_rready_i) ? R_IDLE : r_state_q;
    rdata_d   = ar_hs ? (ar_hit ? regs_q[DATA_WIDTH*ridx +: DATA_WIDTH] : '0) : rdata_q;
    rresp_d   = ar_hs ? (ar_hit ? 2'b00 : 2'b10) : rresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    if (commit && aw_hit) begin
      pulse_d[widx] = 1'b1;
      for (int k = 0; k < SB; k++)
        if (w_strb[k]) regs_d[DATA_WIDTH*widx + 8*k +: 8] = w_data[8*k +: 8];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end
endmodule
